// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the N x N output-stationary systolic multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  // Wide enough for N full signed DW x DW products without wrap.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: multiply-accumulates a paired a/b operand and
// forwards both operands (with their valid bits) to its right/lower neighbours.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = acc_width(DW, 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] a_in,
  input  logic                 a_v_in,
  input  logic signed [DW-1:0] b_in,
  input  logic                 b_v_in,
  input  logic                 clr,
  output logic signed [DW-1:0] a_out,
  output logic                 a_v_out,
  output logic signed [DW-1:0] b_out,
  output logic                 b_v_out,
  output logic signed [AW-1:0] acc
);

  logic signed [DW-1:0]   a_q, b_q;
  logic                   a_v_q, b_v_q;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [2*DW-1:0] prod;

  // Only a slice that is valid on both lanes contributes; bubbles pass through.
  always_comb begin
    prod  = a_in * b_in;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (a_v_in && b_v_in) begin
      acc_d = acc_q + {{(AW - 2 * DW){prod[2*DW-1]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      a_v_q <= 1'b0;
      b_q   <= '0;
      b_v_q <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      a_v_q <= a_v_in;
      b_q   <= b_in;
      b_v_q <= b_v_in;
      acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign a_v_out = a_v_q;
  assign b_out   = b_q;
  assign b_v_out = b_v_q;
  assign acc     = acc_q;

endmodule

// File: rtl/systolic_mul_nxn.sv
// N x N output-stationary systolic multiplier: load handshake, input skew lines,
// PE grid, drain counter and a one-cycle done pulse.
module systolic_mul_nxn
  import systolic_pkg::*;
#(
  parameter int  N  = 2,
  parameter int  DW = 8,
  localparam int AW = acc_width(DW, N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  output logic              busy,
  output logic              done,
  output logic [N*N*AW-1:0] c_out
);

  localparam int CW = (N > 1) ? $clog2(2 * N) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, clr;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One counter serves both phases: beats accepted in LOAD, cycles spent in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          clr     = 1'b1;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt_q == CW'(N - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(2 * N - 2)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q == LOAD) || (state_q == DRAIN);
    done     = (state_q == DONE);
  end

  logic [DW-1:0] a_lane   [N];
  logic          a_lane_v [N];
  logic [DW-1:0] b_lane   [N];
  logic          b_lane_v [N];

  // Lane i is i+1 registers deep, so PE(i,j) sees slice k at accept edge + 1 + i + j.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_q  [i+1];
    logic          av_q [i+1];
    logic [DW-1:0] b_q  [i+1];
    logic          bv_q [i+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s]  <= '0;
          av_q[s] <= 1'b0;
          b_q[s]  <= '0;
          bv_q[s] <= 1'b0;
        end
      end else begin
        a_q[0]  <= a_col[i*DW +: DW];
        av_q[0] <= accept;
        b_q[0]  <= b_row[i*DW +: DW];
        bv_q[0] <= accept;
        for (int s = 1; s <= i; s++) begin
          a_q[s]  <= a_q[s-1];
          av_q[s] <= av_q[s-1];
          b_q[s]  <= b_q[s-1];
          bv_q[s] <= bv_q[s-1];
        end
      end
    end

    assign a_lane[i]   = a_q[i];
    assign a_lane_v[i] = av_q[i];
    assign b_lane[i]   = b_q[i];
    assign b_lane_v[i] = bv_q[i];
  end

  logic [DW-1:0] a_h  [N][N];
  logic          av_h [N][N];
  logic [DW-1:0] b_v  [N][N];
  logic          bv_v [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in_w, b_in_w;
      logic          av_in_w, bv_in_w;

      if (j == 0) begin : g_a_edge
        assign a_in_w  = a_lane[i];
        assign av_in_w = a_lane_v[i];
      end else begin : g_a_fwd
        assign a_in_w  = a_h[i][j-1];
        assign av_in_w = av_h[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in_w  = b_lane[j];
        assign bv_in_w = b_lane_v[j];
      end else begin : g_b_fwd
        assign b_in_w  = b_v[i-1][j];
        assign bv_in_w = bv_v[i-1][j];
      end

      systolic_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in_w),
        .a_v_in (av_in_w),
        .b_in   (b_in_w),
        .b_v_in (bv_in_w),
        .clr    (clr),
        .a_out  (a_h[i][j]),
        .a_v_out(av_h[i][j]),
        .b_out  (b_v[i][j]),
        .b_v_out(bv_v[i][j]),
        .acc    (c_out[(i*N+j)*AW +: AW])
      );
    end
  end

endmodule

// File: tb/tb_systolic_mul_nxn.sv
// Scoreboard bench for systolic_mul_nxn: an N=2 and an N=4 array run side by side
// against a plain matrix-product reference model.
module tb_systolic_mul_nxn;

  localparam int DW = 8;

  logic clk = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   fin [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int N    = (g == 0) ? 2 : 4;
    localparam int AW   = 2 * DW + $clog2(N) + 1;
    localparam int RUNS = (g == 0) ? 12 : 50;

    logic              rst, start, in_valid, in_ready, busy, done;
    logic [N*DW-1:0]   a_col, b_row;
    logic [N*N*AW-1:0] c_out;

    int                matA [N][N];
    int                matB [N][N];
    logic [N*N*AW-1:0] expQ [$];
    int                edgeQ [$];
    logic [N*N*AW-1:0] holdVal;
    bit                hold, prevDone;

    systolic_mul_nxn #(
      .N (N),
      .DW(DW)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a_col   (a_col),
      .b_row   (b_row),
      .busy    (busy),
      .done    (done),
      .c_out   (c_out)
    );

    function automatic logic [N*N*AW-1:0] refMul();
      logic [N*N*AW-1:0] r;
      int                s;
      r = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          s = 0;
          for (int k = 0; k < N; k++) s += matA[i][k] * matB[k][j];
          r[(i*N+j)*AW +: AW] = AW'(s);
        end
      end
      return r;
    endfunction

    task automatic clearMats();
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          matA[i][j] = 0;
          matB[i][j] = 0;
        end
    endtask

    task automatic setStd();
      clearMats();
      matA[0][0] = 1; matA[0][1] = 2; matA[1][0] = 3; matA[1][1] = 4;
      matB[0][0] = 5; matB[0][1] = 6; matB[1][0] = 7; matB[1][1] = 8;
    endtask

    task automatic randomMats();
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          matA[i][j] = int'($urandom_range(0, 255)) - 128;
          matB[i][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic junkInputs();
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = DW'($urandom);
        b_row[i*DW +: DW] = DW'($urandom);
      end
    endtask

    task automatic checkMatrix(input string tag, input logic [N*N*AW-1:0] e);
      logic signed [AW-1:0] got, want;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          got  = c_out[(i*N+j)*AW +: AW];
          want = e[(i*N+j)*AW +: AW];
          compared++;
          if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s N=%0d C[%0d][%0d]: got %0d expected %0d", tag, N, i, j, got, want);
          end
        end
      end
    endtask

    // bubbles < 0 picks 0..3 idle cycles before every beat; otherwise that many between beats.
    task automatic runOnce(input int bubbles, input bit noise, input bit inDone, input bit abortDrain);
      logic [N*N*AW-1:0] e;
      int                waitCnt;
      int                lastEdge;
      e       = refMul();
      waitCnt = 0;
      while ((busy || (inDone && !done)) && waitCnt < 200) begin
        @(negedge clk);
        waitCnt++;
      end
      if (waitCnt >= 200) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL wait_ready N=%0d: got busy=%0b done=%0b after 200 cycles, expected idle", N, busy, done);
        return;
      end
      if (!inDone) repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < N; k++) begin
        int nb;
        nb = (bubbles < 0) ? int'($urandom_range(0, 3)) : ((k == 0) ? 0 : bubbles);
        repeat (nb) begin
          in_valid = 1'b0;
          junkInputs();
          start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          @(negedge clk);
        end
        in_valid = 1'b1;
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int i = 0; i < N; i++) begin
          a_col[i*DW +: DW] = DW'(matA[i][k]);
          b_row[i*DW +: DW] = DW'(matB[k][i]);
        end
        @(negedge clk);
      end
      lastEdge = cyc;
      in_valid = 1'b0;
      start    = 1'b0;
      junkInputs();
      expQ.push_back(e);
      edgeQ.push_back(lastEdge);
      if (abortDrain) begin
        @(posedge clk);
        #3;
        rst = 1'b0;
        void'(expQ.pop_back());
        void'(edgeQ.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end else if (noise) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    endtask

    initial begin
      logic [N*N*AW-1:0] e;
      int                eEdge;
      hold     = 1'b0;
      prevDone = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          compared++;
          if (c_out != '0 || done || busy || in_ready) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs N=%0d: got c_out=%0h done=%0b busy=%0b in_ready=%0b, expected all 0",
                     N, c_out, done, busy, in_ready);
          end
          hold     = 1'b0;
          prevDone = 1'b0;
        end else begin
          if (busy) hold = 1'b0;
          if (done) begin
            compared++;
            if (prevDone) begin
              mismatched++;
              $display("[TB] FAIL done_pulse N=%0d: got done high 2 cycles, expected 1", N);
            end
            if (expQ.size() == 0) begin
              compared++;
              mismatched++;
              $display("[TB] FAIL unexpected_done N=%0d: got done=1, expected no pending result", N);
            end else begin
              e     = expQ.pop_front();
              eEdge = edgeQ.pop_front();
              compared++;
              if (cyc - eEdge != 2 * N - 1) begin
                mismatched++;
                $display("[TB] FAIL done_timing N=%0d: got done %0d edges after last beat, expected %0d",
                         N, cyc - eEdge, 2 * N - 1);
              end
              checkMatrix("c_out", e);
              hold    = 1'b1;
              holdVal = e;
            end
          end else if (hold) begin
            checkMatrix("c_hold", holdVal);
          end
          prevDone = done;
        end
      end
    end

    initial begin
      int waitCnt;
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      a_col    = '0;
      b_row    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      setStd();
      runOnce(0, 1'b0, 1'b0, 1'b0);
      runOnce(3, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          matA[i][j] = -128;
          matB[i][j] = -128;
        end
      runOnce(0, 1'b0, 1'b0, 1'b0);

      randomMats();
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) matA[i][j] = (i == j) ? 1 : 0;
      matB[0][0] = -1;   matB[0][1] = 127;
      matB[1][0] = -128; matB[1][1] = 0;
      runOnce(-1, 1'b0, 1'b0, 1'b0);

      setStd();
      runOnce(0, 1'b1, 1'b0, 1'b0);
      randomMats();
      runOnce(-1, 1'b0, 1'b1, 1'b0);
      randomMats();
      runOnce(0, 1'b0, 1'b0, 1'b1);
      setStd();
      runOnce(0, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < RUNS; r++) begin
        randomMats();
        runOnce(-1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      waitCnt = 0;
      while (expQ.size() != 0 && waitCnt < 100) begin
        @(negedge clk);
        waitCnt++;
      end
      if (expQ.size() != 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL missing_done N=%0d: got %0d results outstanding, expected 0", N, expQ.size());
      end
      repeat (4) @(negedge clk);
      fin[g] = 1'b1;
    end
  end

  initial begin
    wait (fin[0] && fin[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion by 400000, expected both arrays finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/systolic_mul_nxn.md
# systolic_mul_nxn

Parametrised N×N output-stationary systolic matrix multiplier. It is the generalised successor to the fixed 2×2 array. It computes C = A·B for signed N×N operands streamed in one k-slice per beat. Input skew delay lines are built in, and the array provides a valid/ready load handshake, a drain counter and a done pulse. It sits between the operand streamers and the result-collection logic.

## Interface
- N, 2, array dimension (rows = cols = inner dimension); N ≥ 1
- DW, 8, operand width, signed two's complement
- AW, 2*DW+$clog2(N)+1, accumulator / result width; derived, never overridden
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a new multiply; honoured only in IDLE or DONE
- in_valid  in  1  a_col/b_row carry a valid k-slice
- in_ready  out  1  slice accepted when in_valid & in_ready
- a_col  in  N*DW  column k of A; element i at bits [i*DW +: DW]
- b_row  in  N*DW  row k of B; element j at bits [j*DW +: DW]
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse when c_out is final
- c_out  out  N*N*AW  C[i][j] at bits [(i*N+j)*AW +: AW], sign-extended

## Operation
- FSM states: IDLE → LOAD → DRAIN → DONE → IDLE.
  - IDLE/DONE, start=1: clear all accumulators and beat counter; go to LOAD.
  - LOAD: in_ready=1; count accepted beats; on the Nth accept go to DRAIN.
  - DRAIN: count 2N-1 cycles; then go to DONE.
  - DONE: done=1 for exactly this one cycle; go to IDLE, or to LOAD if start=1.
- start in LOAD or DRAIN is ignored (no restart, no corruption).
- Skew: row i operand delayed i cycles; column j operand delayed j cycles. Each lane carries a valid bit alongside data.
- PE(i,j): when a_valid & b_valid, acc += a·b (full signed product, sign-extended to AW). Each cycle it forwards a/valid right and b/valid down through one register. Bubbles (in_valid=0 in LOAD) propagate as invalid and never accumulate.
- c_out is driven directly from the accumulators. It holds its value from DONE until the next start clears it.
- Overflow is impossible by construction of AW; no saturation.
- Reset (any state, including mid-LOAD/DRAIN): FSM→IDLE; in_ready, busy, done = 0; c_out = 0; all skew, PE pipeline valids and accumulators cleared.

## Timing
- start sampled at edge T → in_ready=1 from cycle T+1.
- Last (Nth) beat accepted at edge L → the final accumulate of PE(N-1,N-1) occurs at edge L+2N-1 → done=1 during cycle L+2N. For N=2, done is high at cycle L+4.
- With back-to-back beats from T+1: total latency from start to done = 3N cycles.
- No combinational path from in_valid to in_ready.

## Structure
- Package systolic_pkg: state enum (IDLE, LOAD, DRAIN, DONE) and an acc_width(DW, N) function.
- Sub-module systolic_pe: parameters DW and AW. Ports:
  - a_in, a_v_in, b_in, b_v_in
  - clr
  - a_out, a_v_out, b_out, b_v_out
  - acc
- Top level contains the FSM, counters, skew shift registers (generate loops) and the N×N systolic_pe grid.

## Test plan
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], beats back-to-back → c_out=[[19,22],[43,50]]; done exactly at L+4; single-cycle pulse.
- N=2, same operands, in_valid low for 3 cycles between beats → identical result; done at L+4 relative to the last accepted beat.
- DW=8, N=2, A and B all −128 → every C entry = 32768 (AW=18, no wrap). A=I, B=[[−1,127],[−128,0]] → C=B.
- start pulsed during LOAD and DRAIN → ignored; result and done timing unchanged. start in DONE → next LOAD begins; accumulators cleared.
- rst asserted mid-DRAIN → all outputs 0 asynchronously. After release, a fresh run produces the correct result with no residue.
- N=4, random signed operands, 50 runs checked against a reference model. Verify done at L+8 and that c_out holds until the next start.
